// File: rtl/frame_stack.sv
// Operand stack with hardware call frames: each open frame raises the underflow
// limit, and FRAME_LEAVE slides up to `offset` result values down onto the frame base.
module frame_stack #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int FDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op,
  input  logic [WIDTH-1:0]  data,
  input  logic [DEPTH:0]    offset,
  output logic [DEPTH:0]    index,
  output logic [DEPTH:0]    frame_base,
  output logic [FDEPTH:0]   frame_level,
  output logic [WIDTH-1:0]  out,
  output logic [2:0]        status
);

  localparam int CAP  = 1 << DEPTH;
  localparam int FCAP = 1 << FDEPTH;
  localparam logic [DEPTH:0]  CAP_V   = (DEPTH+1)'(CAP);
  localparam logic [FDEPTH:0] FCAP_V  = (FDEPTH+1)'(FCAP);
  localparam logic [DEPTH:0]  ZERO_V  = '0;
  localparam logic [DEPTH:0]  ONE_V   = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]  TWO_V   = (DEPTH+1)'(2);
  localparam logic [FDEPTH:0] FZERO_V = '0;
  localparam logic [FDEPTH:0] FONE_V  = (FDEPTH+1)'(1);
  localparam logic [FDEPTH:0] FTWO_V  = (FDEPTH+1)'(2);

  localparam logic [3:0] OP_NONE        = 4'd0;
  localparam logic [3:0] OP_PUSH        = 4'd1;
  localparam logic [3:0] OP_POP         = 4'd2;
  localparam logic [3:0] OP_REPLACE     = 4'd3;
  localparam logic [3:0] OP_PEEK        = 4'd4;
  localparam logic [3:0] OP_POKE        = 4'd5;
  localparam logic [3:0] OP_DROP        = 4'd6;
  localparam logic [3:0] OP_FRAME_ENTER = 4'd7;
  localparam logic [3:0] OP_FRAME_LEAVE = 4'd8;

  localparam logic [2:0] ST_NONE      = 3'd0;
  localparam logic [2:0] ST_EMPTY     = 3'd1;
  localparam logic [2:0] ST_FULL      = 3'd2;
  localparam logic [2:0] ST_OVERFLOW  = 3'd3;
  localparam logic [2:0] ST_UNDERFLOW = 3'd4;
  localparam logic [2:0] ST_FOVERFLOW = 3'd5;
  localparam logic [2:0] ST_FUNDERFLOW = 3'd6;

  typedef enum logic [0:0] {IDLE = 1'b0, COPY = 1'b1} state_t;

  state_t               state_r, state_n;
  logic [WIDTH-1:0]     mem [CAP];
  logic [DEPTH:0]       frames [FCAP];
  logic [DEPTH:0]       index_r, index_n;
  logic [DEPTH:0]       base_r, base_n;
  logic [FDEPTH:0]      level_r, level_n;
  logic [WIDTH-1:0]     out_r, out_n;
  logic [2:0]           status_r, status_n;
  logic [DEPTH:0]       src_r, src_n;
  logic [DEPTH:0]       dst_r, dst_n;
  logic [DEPTH:0]       cnt_r, cnt_n;
  logic [DEPTH:0]       keep_r, keep_n;

  logic [2:0]           err_s;
  logic                 mem_we_s;
  logic [DEPTH:0]       mem_addr_s;
  logic [WIDTH-1:0]     mem_wdata_s;
  logic                 frame_we_s;
  logic [3:0]           op_eff_s;
  logic [DEPTH:0]       avail_s;
  logic [DEPTH:0]       idx_m1_s;
  logic [DEPTH:0]       idx_m2_s;
  logic [DEPTH:0]       peek_addr_s;
  logic [DEPTH:0]       drop_idx_s;
  logic [DEPTH:0]       drop_top_addr_s;
  logic [DEPTH:0]       leave_src_s;
  logic [FDEPTH:0]      level_m2_s;
  logic [DEPTH:0]       prev_base_s;
  logic [WIDTH-1:0]     top_s;
  logic [WIDTH-1:0]     below_s;
  logic [WIDTH-1:0]     peek_s;
  logic [WIDTH-1:0]     drop_top_s;
  logic [WIDTH-1:0]     copy_val_s;

  // Address arithmetic is all DEPTH+1 bits; the array is indexed by the low DEPTH bits.
  assign op_eff_s        = op_valid ? op : OP_NONE;
  assign avail_s         = index_r - base_r;
  assign idx_m1_s        = index_r - ONE_V;
  assign idx_m2_s        = index_r - TWO_V;
  assign peek_addr_s     = index_r - ONE_V - offset;
  assign drop_idx_s      = index_r - offset;
  assign drop_top_addr_s = drop_idx_s - ONE_V;
  assign leave_src_s     = index_r - offset;
  assign level_m2_s      = level_r - FTWO_V;
  assign prev_base_s     = (level_r >= FTWO_V) ? frames[level_m2_s[FDEPTH-1:0]] : ZERO_V;
  assign top_s           = mem[idx_m1_s[DEPTH-1:0]];
  assign below_s         = mem[idx_m2_s[DEPTH-1:0]];
  assign peek_s          = mem[peek_addr_s[DEPTH-1:0]];
  assign drop_top_s      = mem[drop_top_addr_s[DEPTH-1:0]];
  assign copy_val_s      = mem[src_r[DEPTH-1:0]];

  // Next-state, storage writes and error detection for both FSM states.
  always_comb begin
    state_n     = state_r;
    index_n     = index_r;
    base_n      = base_r;
    level_n     = level_r;
    out_n       = out_r;
    err_s       = ST_NONE;
    mem_we_s    = 1'b0;
    mem_addr_s  = index_r;
    mem_wdata_s = data;
    frame_we_s  = 1'b0;
    src_n       = src_r;
    dst_n       = dst_r;
    cnt_n       = cnt_r;
    keep_n      = keep_r;
    case (state_r)
      IDLE: begin
        case (op_eff_s)
          OP_PUSH: begin
            if (index_r == CAP_V) begin
              err_s = ST_OVERFLOW;
            end else begin
              mem_we_s   = 1'b1;
              mem_addr_s = index_r;
              index_n    = index_r + ONE_V;
              out_n      = data;
            end
          end
          OP_POP: begin
            if (avail_s == ZERO_V) begin
              err_s = ST_UNDERFLOW;
            end else begin
              index_n = idx_m1_s;
              if (avail_s > ONE_V) begin
                out_n = below_s;
              end else begin
                out_n = out_r;
              end
            end
          end
          OP_REPLACE: begin
            if (avail_s == ZERO_V) begin
              err_s = ST_UNDERFLOW;
            end else begin
              mem_we_s   = 1'b1;
              mem_addr_s = idx_m1_s;
              out_n      = data;
            end
          end
          OP_PEEK: begin
            if (offset >= avail_s) begin
              err_s = ST_UNDERFLOW;
            end else begin
              out_n = peek_s;
            end
          end
          OP_POKE: begin
            if (offset >= avail_s) begin
              err_s = ST_UNDERFLOW;
            end else begin
              mem_we_s   = 1'b1;
              mem_addr_s = peek_addr_s;
              out_n      = data;
            end
          end
          OP_DROP: begin
            if (offset > avail_s) begin
              err_s = ST_UNDERFLOW;
            end else if (offset == ZERO_V) begin
              out_n = out_r;
            end else begin
              index_n = drop_idx_s;
              if (offset < avail_s) begin
                out_n = drop_top_s;
              end else begin
                out_n = out_r;
              end
            end
          end
          OP_FRAME_ENTER: begin
            if (level_r == FCAP_V) begin
              err_s = ST_FOVERFLOW;
            end else begin
              frame_we_s = 1'b1;
              level_n    = level_r + FONE_V;
              base_n     = index_r;
            end
          end
          OP_FRAME_LEAVE: begin
            if (level_r == FZERO_V) begin
              err_s = ST_FUNDERFLOW;
            end else if (offset > avail_s) begin
              err_s = ST_UNDERFLOW;
            end else if ((offset == ZERO_V) || (leave_src_s == base_r)) begin
              // Results already sit on the base: close the frame in place.
              index_n = base_r + offset;
              level_n = level_r - FONE_V;
              base_n  = prev_base_s;
              if (offset != ZERO_V) begin
                out_n = top_s;
              end else begin
                out_n = out_r;
              end
            end else begin
              state_n = COPY;
              src_n   = leave_src_s;
              dst_n   = base_r;
              cnt_n   = offset;
              keep_n  = offset;
            end
          end
          default: begin
            if (avail_s != ZERO_V) begin
              out_n = top_s;
            end else begin
              out_n = out_r;
            end
          end
        endcase
      end
      COPY: begin
        // Source is always above destination, so ascending order never clobbers unread data.
        mem_we_s    = 1'b1;
        mem_addr_s  = dst_r;
        mem_wdata_s = copy_val_s;
        src_n       = src_r + ONE_V;
        dst_n       = dst_r + ONE_V;
        cnt_n       = cnt_r - ONE_V;
        if (cnt_r == ONE_V) begin
          state_n = IDLE;
          index_n = base_r + keep_r;
          level_n = level_r - FONE_V;
          base_n  = prev_base_s;
          out_n   = copy_val_s;
        end else begin
          state_n = COPY;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Status reflects the post-edge state unless an error is being reported.
  always_comb begin
    status_n = ST_NONE;
    if (err_s != ST_NONE) begin
      status_n = err_s;
    end else if (index_n == CAP_V) begin
      status_n = ST_FULL;
    end else if (index_n == base_n) begin
      status_n = ST_EMPTY;
    end else begin
      status_n = ST_NONE;
    end
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      index_r  <= '0;
      base_r   <= '0;
      level_r  <= '0;
      out_r    <= '0;
      status_r <= ST_EMPTY;
      src_r    <= '0;
      dst_r    <= '0;
      cnt_r    <= '0;
      keep_r   <= '0;
    end else begin
      state_r  <= state_n;
      index_r  <= index_n;
      base_r   <= base_n;
      level_r  <= level_n;
      out_r    <= out_n;
      status_r <= status_n;
      src_r    <= src_n;
      dst_r    <= dst_n;
      cnt_r    <= cnt_n;
      keep_r   <= keep_n;
    end
  end

  // Operand and frame storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_addr_s[DEPTH-1:0]] <= mem_wdata_s;
    end
    if (frame_we_s) begin
      frames[level_r[FDEPTH-1:0]] <= index_r;
    end
  end

  assign op_ready    = (state_r == IDLE);
  assign index       = index_r;
  assign frame_base  = base_r;
  assign frame_level = level_r;
  assign out         = out_r;
  assign status      = status_r;

endmodule

// File: doc/frame_stack.md
# frame_stack

Parametrised operand stack with hardware call frames, the successor to the single-limit stack used by the WebAssembly core. Each FRAME_ENTER saves the current stack index on an internal frame stack, and that saved base becomes the underflow limit. FRAME_LEAVE discards the frame and moves up to `offset` result values down onto the base. The block sits between the instruction decoder (valid/ready op port) and the execute stage (`out`/`status`).

## Interface
- `WIDTH`, 8, data word width
- `DEPTH`, 4, log2 of stack capacity; CAP = 2^DEPTH entries
- `FDEPTH`, 2, log2 of frame-stack capacity; FCAP = 2^FDEPTH frames
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low (0 = reset)
- `op_valid`  in  1  op request
- `op_ready`  out  1  high when idle; op accepted on `op_valid && op_ready` at a rising edge
- `op`  in  4  operation code (see Operation)
- `data`  in  WIDTH  write data
- `offset`  in  DEPTH+1  peek/poke depth, drop count, or FRAME_LEAVE keep count
- `index`  out  DEPTH+1  number of live entries, 0..CAP
- `frame_base`  out  DEPTH+1  current underflow limit (0 when no frame is open)
- `frame_level`  out  FDEPTH+1  number of open frames
- `out`  out  WIDTH  registered result / top of frame
- `status`  out  3  NONE=0, EMPTY=1, FULL=2, OVERFLOW=3, UNDERFLOW=4, FRAME_OVERFLOW=5, FRAME_UNDERFLOW=6

## Operation
- Storage: CAP×WIDTH register array with combinational read, plus FCAP×(DEPTH+1) frame array. `avail = index - frame_base`, unsigned, never negative.
- The ops below act only when the op is accepted. Any error leaves storage, index and frames unchanged, and `out` holds.
- 0 NONE: if avail>0, `out` = mem[index-1].
- 1 PUSH: if index==CAP → OVERFLOW. Else mem[index]=data, index+1, `out`=data.
- 2 POP: if avail==0 → UNDERFLOW. Else index-1. `out`=mem[index-2] if the new avail>0, else `out` holds.
- 3 REPLACE: if avail==0 → UNDERFLOW. Else mem[index-1]=data, `out`=data.
- 4 PEEK: if offset≥avail → UNDERFLOW. Else `out`=mem[index-1-offset].
- 5 POKE: if offset≥avail → UNDERFLOW. Else mem[index-1-offset]=data, `out`=data.
- 6 DROP: if offset>avail → UNDERFLOW. Else index-=offset; `out` = new top if avail>0 afterwards. offset=0 is a no-op.
- 7 FRAME_ENTER: if frame_level==FCAP → FRAME_OVERFLOW. Else push index onto frames; frame_base=index.
- 8 FRAME_LEAVE (keep=offset): if frame_level==0 → FRAME_UNDERFLOW; if keep>avail → UNDERFLOW.
  - Otherwise the move is skipped when keep==0 or index-keep==base: index=base+keep, frame popped, `frame_base` = next saved base or 0.
  - Otherwise enter COPY and move mem[index-keep+i] → mem[base+i] for i=0..keep-1, lowest i first, one entry per cycle.
  - On completion, `out`=mem[base+keep-1] (the copied value) if keep>0.
- 9–15: treated as NONE.
- Non-error status after every edge, recomputed from the new state: FULL if index==CAP, else EMPTY if avail==0, else NONE. Error codes last exactly one cycle.
- No accepted op (op_valid low) behaves as NONE, so status stays current. This includes an UNDERFLOW caused by external limit changes, which cannot occur here because the limit is internal.

## Timing
- Reset (async assert, sync-safe release): index=0, frame_base=0, frame_level=0, out=0, status=EMPTY, op_ready=1, FSM=IDLE. Memory contents are not reset.
- FSM states: IDLE and COPY.
  - IDLE: all ops complete at the accepting edge; results visible the next cycle.
  - IDLE→COPY on an accepted FRAME_LEAVE that needs a move. `op_ready` is low for the whole of COPY.
  - COPY runs keep cycles, one copy per edge. The last copy edge commits index, frames, `out` and `status`, then returns to IDLE.
- FRAME_LEAVE latency is 1 edge without a move, keep+1 edges with a move (accept + keep copies). `index`/`frame_level` are unchanged during COPY, and status is NONE/EMPTY/FULL of the pre-leave state.
- Reset asserted mid-COPY aborts the copy immediately. Partially moved memory is left as is.
- Width: all index arithmetic is DEPTH+1 bits; comparisons are unsigned. `offset` wider than avail is always a range error, never a wrap.

## Test plan
WIDTH=8, DEPTH=2 (CAP=4), FDEPTH=1 (FCAP=2) unless noted.
- Reset, then POP → status UNDERFLOW, index 0. Then PUSH 1,2,3,4 → status FULL, out 0x04, index 4. Then PUSH 5 → OVERFLOW, out 0x04, index 4.
- Reset, PUSH 0xA, FRAME_ENTER → frame_base 1, status EMPTY. Then POP → UNDERFLOW, index 1. Then PEEK offset 0 → UNDERFLOW.
- Reset, PUSH 0xA, FRAME_ENTER, PUSH 0xB, PUSH 0xC, PUSH 0xD, FRAME_LEAVE keep 2:
  - op_ready low for exactly 2 cycles.
  - Then index 3, frame_level 0, mem = {0xA,0xC,0xD}, out 0x0D.
  - POP → out 0x0C.
- PEEK/POKE/DROP on stack {1,2,3}:
  - PEEK offset 2 → out 0x01.
  - POKE offset 1 data 0x22 → PEEK offset 1 = 0x22.
  - DROP offset 4 → UNDERFLOW.
  - DROP offset 2 → index 1, out 0x01.
- Frame limits: FRAME_ENTER ×2 → level 2; third → FRAME_OVERFLOW. FRAME_LEAVE ×2 (keep 0) → level 0; third → FRAME_UNDERFLOW.
- Assert reset during the COPY of the scenario above → op_ready 1, index 0, frame_level 0, status EMPTY, out 0 in the same cycle.
